multicycle_control_fsm: RTL and testbench
=========================================

MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 Parameter ALUOP_W, default 4: width of aluop; SHALL be >= 4; codes zero-extended to this width.
REQ-002 Parameter MEM_WAIT_EN, default 1: 1 waits for mem_ready; 0 SHALL treat mem_ready as constant 1.
REQ-003 Parameter BNE_EN, default 1: 1 decodes bne (opcode 000101); 0 treats it as illegal.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 opcode  in  6  instruction[31:26] from the instruction register.
REQ-007 func  in  6  instruction[5:0].
REQ-008 zero_flag  in  1  ALU zero result.
REQ-009 mem_ready  in  1  memory access completes this cycle.
REQ-010 regdst, regwrite, extop, alusrc, mem2reg  out  1 each  datapath selects; mem2reg=1 selects ALU result, 0 selects memory data.
REQ-011 aluop  out  ALUOP_W  ALU operation code.
REQ-012 memread, memwrite, irwrite, pcwrite  out  1 each  memory and register strobes.
REQ-013 pcsrc  out  2  PC source: 0 PC+4, 1 branch target, 2 jump target.
REQ-014 state  out  3  current state encoding.
REQ-015 illegal  out  1  one-cycle pulse on an undecodable instruction.

Function
REQ-016 States: FETCH=0, DECODE=1, EXEC=2, MEMACC=3, WBACK=4; encodings 5-7 SHALL go to FETCH on the next edge.
REQ-017 FETCH: memread=1; on mem_ready: irwrite=1, pcwrite=1, pcsrc=0, go to DECODE; otherwise hold with no other strobes.
REQ-018 DECODE: register opcode and func internally; they are held until the next FETCH, so later input changes have no effect.
REQ-019 Decoding: R-type (000000) func 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; addi 001000; lw 100011; sw 101011; beq 000100; bne 000101 (if BNE_EN); j 000010.
REQ-020 DECODE with j: pcwrite=1, pcsrc=2, go to FETCH.
REQ-021 DECODE with an illegal opcode/func: illegal=1 for that cycle, no strobes, go to FETCH.
REQ-022 DECODE otherwise: go to EXEC.
REQ-023 aluop in EXEC: add 0010, sub 0110, and 0000, or 0001, slt 0111; addi/lw/sw 0010; beq/bne 0110.
REQ-024 EXEC, R-type: alusrc=0, go to WBACK.
REQ-025 EXEC, addi: alusrc=1, extop=1, go to WBACK.
REQ-026 EXEC, lw/sw: alusrc=1, extop=1, go to MEMACC.
REQ-027 EXEC, beq: alusrc=0, extop=1, pcsrc=1, pcwrite=zero_flag, go to FETCH.
REQ-028 EXEC, bne: as beq but pcwrite=~zero_flag.
REQ-029 MEMACC, lw: memread=1 until mem_ready, then go to WBACK.
REQ-030 MEMACC, sw: memwrite=1 until mem_ready, then go to FETCH; memwrite SHALL NOT be asserted outside MEMACC.
REQ-031 WBACK: regwrite=1 for exactly one cycle, then go to FETCH.
REQ-032 WBACK select lines: R-type regdst=1, mem2reg=1; addi regdst=0, mem2reg=1; lw regdst=0, mem2reg=0.
REQ-033 Any output not listed for a state SHALL be 0.
REQ-034 Latency with zero wait states: j 2 cycles; beq/bne 3; R-type/addi/sw 4; lw 5. Each mem_ready=0 cycle in FETCH or MEMACC adds 1.
REQ-035 Memory strobes and the state are held unchanged while mem_ready=0; there is no timeout.

Reset
REQ-036 In any cycle with rst_n=0, every output is 0 (including memread), and on the next edge state=FETCH and the internal opcode/func registers clear to 0.
REQ-037 Reset asserted mid-instruction (including during a MEMACC wait) SHALL abort the instruction with no regwrite, memwrite or pcwrite in the reset cycle.

Verification
REQ-038 add (000000/100000), mem_ready=1 -> state 0,1,2,4,0; aluop=0010 in EXEC; regwrite=1, regdst=1, mem2reg=1 in WBACK only.
REQ-039 lw with mem_ready low for 2 cycles in MEMACC -> memread held 3 cycles; then WBACK with mem2reg=0, regdst=0; 7 cycles total.
REQ-040 beq with zero_flag=1, then with zero_flag=0 -> pcwrite=1, pcsrc=1 in EXEC, then pcwrite=0; both return to FETCH after 3 cycles.
REQ-041 opcode 111111 -> illegal pulses 1 cycle in DECODE, no strobes, FETCH next; with BNE_EN=0, opcode 000101 -> illegal=1.
REQ-042 rst_n=0 during the sw MEMACC wait -> memwrite=0 that cycle, state=0 the next cycle; the next fetch proceeds normally.
REQ-043 MEM_WAIT_EN=0 with mem_ready tied to 0 -> lw completes in 5 cycles.

Source files
------------

// File: rtl/multicycle_control_fsm_if.sv
// multicycle_control_fsm_if: instruction/status inputs and datapath control outputs of the multicycle controller
interface multicycle_control_fsm_if #(parameter int ALUOP_W = 4);
  logic [5:0] opcode;
  logic [5:0] func;
  logic zero_flag;
  logic mem_ready;
  logic regdst;
  logic regwrite;
  logic extop;
  logic alusrc;
  logic mem2reg;
  logic [ALUOP_W-1:0] aluop;
  logic memread;
  logic memwrite;
  logic irwrite;
  logic pcwrite;
  logic [1:0] pcsrc;
  logic [2:0] state;
  logic illegal;
  modport master (
    input opcode, func, zero_flag, mem_ready,
    output regdst, regwrite, extop, alusrc, mem2reg, aluop,
    output memread, memwrite, irwrite, pcwrite, pcsrc, state, illegal
  );
  modport slave (
    output opcode, func, zero_flag, mem_ready,
    input regdst, regwrite, extop, alusrc, mem2reg, aluop,
    input memread, memwrite, irwrite, pcwrite, pcsrc, state, illegal
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: five-state MIPS-subset controller (fetch, decode, execute, memory, writeback)
module multicycle_control_fsm #(
  parameter int ALUOP_W     = 4,
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter bit BNE_EN      = 1'b1
) (
  input logic clk,
  input logic rst_n,
  multicycle_control_fsm_if.master bus
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEMACC, WBACK} state_t;
  typedef enum logic [3:0] {
    I_ADD, I_SUB, I_AND, I_OR, I_SLT, I_ADDI, I_LW, I_SW, I_BEQ, I_BNE, I_J, I_ILL
  } instr_t;
  if (ALUOP_W < 4) begin : g_aluop_w_check
    $error("ALUOP_W must be at least 4");
  end
  state_t st;
  logic [5:0] op_q;
  logic [5:0] fn_q;
  logic ready;
  instr_t live;
  instr_t cur;
  function automatic instr_t dec(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000:
        case (fn)
          6'b100000: return I_ADD;
          6'b100010: return I_SUB;
          6'b100100: return I_AND;
          6'b100101: return I_OR;
          6'b101010: return I_SLT;
          default:   return I_ILL;
        endcase
      6'b001000: return I_ADDI;
      6'b100011: return I_LW;
      6'b101011: return I_SW;
      6'b000100: return I_BEQ;
      6'b000101: if (BNE_EN) return I_BNE; else return I_ILL;
      6'b000010: return I_J;
      default:   return I_ILL;
    endcase
  endfunction
  function automatic logic [3:0] alu_code(input instr_t i);
    case (i)
      I_SUB, I_BEQ, I_BNE: return 4'b0110;
      I_AND:               return 4'b0000;
      I_OR:                return 4'b0001;
      I_SLT:               return 4'b0111;
      default:             return 4'b0010;
    endcase
  endfunction
  assign ready = MEM_WAIT_EN ? bus.mem_ready : 1'b1;
  // DECODE acts on the live instruction; later states use the copy captured in DECODE
  assign live  = dec(bus.opcode, bus.func);
  assign cur   = dec(op_q, fn_q);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st   <= FETCH;
      op_q <= '0;
      fn_q <= '0;
    end else begin
      if (st == DECODE) begin
        op_q <= bus.opcode;
        fn_q <= bus.func;
      end
      case (st)
        FETCH:   st <= ready ? DECODE : FETCH;
        DECODE:  st <= (live == I_J || live == I_ILL) ? FETCH : EXEC;
        EXEC:    st <= (cur inside {I_LW, I_SW}) ? MEMACC : (cur inside {I_BEQ, I_BNE}) ? FETCH : WBACK;
        MEMACC:  st <= !ready ? MEMACC : (cur == I_LW) ? WBACK : FETCH;
        default: st <= FETCH;
      endcase
    end
  end
  // Outputs are decoded from the state register plus same-cycle handshake inputs, forced low during reset
  always_comb begin
    bus.regdst   = 1'b0;
    bus.regwrite = 1'b0;
    bus.extop    = 1'b0;
    bus.alusrc   = 1'b0;
    bus.mem2reg  = 1'b0;
    bus.aluop    = '0;
    bus.memread  = 1'b0;
    bus.memwrite = 1'b0;
    bus.irwrite  = 1'b0;
    bus.pcwrite  = 1'b0;
    bus.pcsrc    = 2'd0;
    bus.illegal  = 1'b0;
    bus.state    = rst_n ? st : 3'd0;
    if (rst_n) begin
      case (st)
        FETCH: begin
          bus.memread = 1'b1;
          bus.irwrite = ready;
          bus.pcwrite = ready;
        end
        DECODE: begin
          bus.illegal = live == I_ILL;
          bus.pcwrite = live == I_J;
          bus.pcsrc   = live == I_J ? 2'd2 : 2'd0;
        end
        EXEC: begin
          bus.aluop   = ALUOP_W'(alu_code(cur));
          bus.alusrc  = cur inside {I_ADDI, I_LW, I_SW};
          bus.extop   = cur inside {I_ADDI, I_LW, I_SW, I_BEQ, I_BNE};
          bus.pcsrc   = (cur inside {I_BEQ, I_BNE}) ? 2'd1 : 2'd0;
          bus.pcwrite = cur == I_BEQ ? bus.zero_flag : cur == I_BNE ? ~bus.zero_flag : 1'b0;
        end
        MEMACC: begin
          bus.memread  = cur == I_LW;
          bus.memwrite = cur == I_SW;
        end
        WBACK: begin
          bus.regwrite = 1'b1;
          bus.regdst   = cur inside {I_ADD, I_SUB, I_AND, I_OR, I_SLT};
          bus.mem2reg  = cur != I_LW;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: per-cycle vector table through a scoreboard queue, plus parameter-variant sequences
module tb_multicycle_control_fsm;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  multicycle_control_fsm_if #(.ALUOP_W(4)) bm ();
  multicycle_control_fsm_if #(.ALUOP_W(4)) bb ();
  multicycle_control_fsm_if #(.ALUOP_W(4)) bw ();
  multicycle_control_fsm dut (.clk(clk), .rst_n(rst_n), .bus(bm));
  multicycle_control_fsm #(.BNE_EN(1'b0)) dut_nb (.clk(clk), .rst_n(rst_n), .bus(bb));
  multicycle_control_fsm #(.MEM_WAIT_EN(1'b0)) dut_nw (.clk(clk), .rst_n(rst_n), .bus(bw));
  assign bb.opcode = bm.opcode;
  assign bb.func = bm.func;
  assign bb.zero_flag = bm.zero_flag;
  assign bb.mem_ready = bm.mem_ready;
  assign bw.opcode = bm.opcode;
  assign bw.func = bm.func;
  assign bw.zero_flag = bm.zero_flag;
  assign bw.mem_ready = 1'b0;
  // {illegal, regdst, regwrite, extop, alusrc, mem2reg, aluop[3:0], memread, memwrite, irwrite, pcwrite, pcsrc[1:0]}
  logic [15:0] ctl_m, ctl_b, ctl_w;
  assign ctl_m = {bm.illegal, bm.regdst, bm.regwrite, bm.extop, bm.alusrc, bm.mem2reg, bm.aluop,
                  bm.memread, bm.memwrite, bm.irwrite, bm.pcwrite, bm.pcsrc};
  assign ctl_b = {bb.illegal, bb.regdst, bb.regwrite, bb.extop, bb.alusrc, bb.mem2reg, bb.aluop,
                  bb.memread, bb.memwrite, bb.irwrite, bb.pcwrite, bb.pcsrc};
  assign ctl_w = {bw.illegal, bw.regdst, bw.regwrite, bw.extop, bw.alusrc, bw.mem2reg, bw.aluop,
                  bw.memread, bw.memwrite, bw.irwrite, bw.pcwrite, bw.pcsrc};
  localparam logic [15:0] ILL = 16'h8000, RD = 16'h4000, RW = 16'h2000, EXT = 16'h1000;
  localparam logic [15:0] ASRC = 16'h0800, M2R = 16'h0400, MRD = 16'h0020, MWR = 16'h0010;
  localparam logic [15:0] IRW = 16'h0008, PCW = 16'h0004, PBR = 16'h0001, PJ = 16'h0002;
  localparam logic [15:0] FT = MRD | IRW | PCW;
  localparam logic [5:0] R = 6'h00, ADDI = 6'h08, LW = 6'h23, SW = 6'h2b, BEQ = 6'h04, BNE = 6'h05, J = 6'h02;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2a;
  function automatic logic [15:0] alu(input logic [3:0] c);
    return {6'b0, c, 6'b0};
  endfunction
  typedef struct {
    logic rst_n;
    logic [5:0] op;
    logic [5:0] fn;
    logic z;
    logic mr;
    logic [2:0] st;
    logic [15:0] ctl;
  } vec_t;
  typedef struct {
    int idx;
    logic [2:0] st;
    logic [15:0] ctl;
  } exp_t;
  vec_t vec[$];
  exp_t sb[$];
  int total = 0;
  int bad = 0;
  task automatic v(input logic r, input logic [5:0] o, input logic [5:0] f, input logic z, input logic mr,
                   input logic [2:0] s, input logic [15:0] c);
    vec.push_back('{r, o, f, z, mr, s, c});
  endtask
  task automatic ins4(input logic [5:0] o, input logic [5:0] f, input logic [15:0] ex, input logic [15:0] wb);
    v(1, o, f, 0, 1, 0, FT);
    v(1, o, f, 0, 1, 1, 0);
    v(1, o, f, 0, 1, 2, ex);
    v(1, o, f, 0, 1, 4, wb);
  endtask
  task automatic branch(input logic [5:0] o, input logic z, input logic [15:0] ex);
    v(1, o, 0, z, 1, 0, FT);
    v(1, o, 0, z, 1, 1, 0);
    v(1, o, 0, z, 1, 2, ex);
  endtask
  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic drive(input logic r, input logic [5:0] o, input logic [5:0] f, input logic z, input logic mr);
    @(posedge clk);
    #1;
    rst_n = r;
    bm.opcode = o;
    bm.func = f;
    bm.zero_flag = z;
    bm.mem_ready = mr;
  endtask
  logic [2:0] nw_st[6];
  logic [15:0] nw_ctl[6];
  initial begin
    exp_t e;
    rst_n = 1'b0;
    bm.opcode = '0;
    bm.func = '0;
    bm.zero_flag = 1'b0;
    bm.mem_ready = 1'b1;
    v(0, R, F_ADD, 0, 1, 0, 0);
    v(0, R, F_ADD, 0, 1, 0, 0);
    ins4(R, F_ADD, alu(4'b0010), RW | RD | M2R);
    ins4(R, F_SUB, alu(4'b0110), RW | RD | M2R);
    ins4(R, F_AND, alu(4'b0000), RW | RD | M2R);
    ins4(R, F_OR, alu(4'b0001), RW | RD | M2R);
    ins4(R, F_SLT, alu(4'b0111), RW | RD | M2R);
    ins4(ADDI, 0, alu(4'b0010) | ASRC | EXT, RW | M2R);
    v(1, LW, 0, 0, 1, 0, FT);
    v(1, LW, 0, 0, 1, 1, 0);
    v(1, LW, 0, 0, 1, 2, alu(4'b0010) | ASRC | EXT);
    v(1, LW, 0, 0, 0, 3, MRD);
    v(1, LW, 0, 0, 0, 3, MRD);
    v(1, LW, 0, 0, 1, 3, MRD);
    v(1, LW, 0, 0, 1, 4, RW);
    ins4(SW, 0, alu(4'b0010) | ASRC | EXT, 0);
    vec[$].st = 3;
    vec[$].ctl = MWR;
    branch(BEQ, 1, alu(4'b0110) | EXT | PBR | PCW);
    branch(BEQ, 0, alu(4'b0110) | EXT | PBR);
    branch(BNE, 0, alu(4'b0110) | EXT | PBR | PCW);
    branch(BNE, 1, alu(4'b0110) | EXT | PBR);
    v(1, J, 0, 0, 1, 0, FT);
    v(1, J, 0, 0, 1, 1, PCW | PJ);
    v(1, 6'h3f, 0, 0, 1, 0, FT);
    v(1, 6'h3f, 0, 0, 1, 1, ILL);
    v(1, R, 6'h3f, 0, 1, 0, FT);
    v(1, R, 6'h3f, 0, 1, 1, ILL);
    v(1, R, F_ADD, 0, 1, 0, FT);
    v(1, R, F_ADD, 0, 1, 1, 0);
    v(1, 6'h3f, 6'h3f, 0, 1, 2, alu(4'b0010));
    v(1, 6'h3f, 0, 0, 1, 4, RW | RD | M2R);
    v(1, J, 0, 0, 0, 0, MRD);
    v(1, J, 0, 0, 0, 0, MRD);
    v(1, J, 0, 0, 1, 0, FT);
    v(1, J, 0, 0, 1, 1, PCW | PJ);
    v(1, SW, 0, 0, 1, 0, FT);
    v(1, SW, 0, 0, 1, 1, 0);
    v(1, SW, 0, 0, 1, 2, alu(4'b0010) | ASRC | EXT);
    v(1, SW, 0, 0, 0, 3, MWR);
    v(0, SW, 0, 0, 0, 0, 0);
    ins4(R, F_ADD, alu(4'b0010), RW | RD | M2R);
    for (int i = 0; i < vec.size(); i++) begin
      drive(vec[i].rst_n, vec[i].op, vec[i].fn, vec[i].z, vec[i].mr);
      sb.push_back('{i, vec[i].st, vec[i].ctl});
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("row%0d state", e.idx), {13'd0, bm.state}, {13'd0, e.st});
      check($sformatf("row%0d ctl", e.idx), ctl_m, e.ctl);
    end
    drive(0, BNE, 0, 0, 1);
    drive(1, BNE, 0, 0, 1);
    @(negedge clk);
    check("nobne fetch state", {13'd0, bb.state}, 16'd0);
    check("nobne fetch ctl", ctl_b, FT);
    drive(1, BNE, 0, 0, 1);
    @(negedge clk);
    check("nobne decode state", {13'd0, bb.state}, 16'd1);
    check("nobne decode illegal", ctl_b, ILL);
    check("bne legal decode ctl", ctl_m, 16'd0);
    drive(1, BNE, 0, 0, 1);
    @(negedge clk);
    check("nobne back to fetch", {13'd0, bb.state}, 16'd0);
    check("bne exec state", {13'd0, bm.state}, 16'd2);
    nw_st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    nw_ctl = '{FT, 16'd0, alu(4'b0010) | ASRC | EXT, MRD, RW, FT};
    drive(0, LW, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(1, LW, 0, 0, 0);
      @(negedge clk);
      check($sformatf("nowait c%0d state", i), {13'd0, bw.state}, {13'd0, nw_st[i]});
      check($sformatf("nowait c%0d ctl", i), ctl_w, nw_ctl[i]);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
